// File: rtl/NVP_v1_constants.sv
// NVP_v1_constants: fixed-point widths shared across the NVP datapath
package NVP_v1_constants;
    localparam int DATA_WIDTH        = 16;
    localparam int HALF_DATA_WIDTH   = 8;
    localparam int UNQUANTIZED_WIDTH = 48;
endpackage

// File: rtl/NVP_v1_package.sv
// NVP_v1_package: operand/accumulator types, dequantize helper and dequantizer states
package NVP_v1_package;
    import NVP_v1_constants::*;
    typedef logic [DATA_WIDTH-1:0]        data_t;
    typedef logic [UNQUANTIZED_WIDTH-1:0] unquantized_t;
    typedef enum logic [1:0] {IDLE, LOAD, EMIT} dequant_state_t;
    // 8.8 -> 32.16: sign-extend, then align the binary point; always exact
    function automatic unquantized_t f_dequantize(input data_t x);
        return {{(UNQUANTIZED_WIDTH-DATA_WIDTH-HALF_DATA_WIDTH){x[DATA_WIDTH-1]}}, x, {HALF_DATA_WIDTH{1'b0}}};
    endfunction
endpackage

// File: rtl/nvp_bias_dequantizer.sv
// nvp_bias_dequantizer: unpacks words of 8.8 operands and streams them out as 32.16 accumulator preloads
module nvp_bias_dequantizer
    import NVP_v1_constants::*, NVP_v1_package::*;
#(
    parameter int WORD_LANES  = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_start,
    input  logic [COUNT_WIDTH-1:0]           cfg_num_values,
    output logic                             busy,
    output logic                             done,
    input  logic [WORD_LANES*DATA_WIDTH-1:0] s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic [UNQUANTIZED_WIDTH-1:0]     m_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic                             m_last
);
    localparam int LW = WORD_LANES > 1 ? $clog2(WORD_LANES) : 1;
    dequant_state_t state, state_nx;
    logic [COUNT_WIDTH-1:0] cnt, num, cnt_inc;
    logic [LW-1:0] lane, lane_nx;
    logic [WORD_LANES*DATA_WIDTH-1:0] word;
    unquantized_t data_q;
    logic done_q, is_last, lane_last, zero_start;
    assign cnt_inc    = cnt + COUNT_WIDTH'(1);
    assign lane_nx    = lane + LW'(1);
    assign is_last    = cnt_inc == num;
    assign lane_last  = lane == LW'(WORD_LANES-1);
    assign zero_start = state == IDLE && cfg_start && cfg_num_values == '0;
    assign busy    = state != IDLE;
    assign s_ready = state == LOAD;
    assign m_valid = state == EMIT;
    assign m_last  = state == EMIT && is_last;
    assign m_data  = data_q;
    assign done    = done_q;
    always_comb begin
        state_nx = state;
        if (state == IDLE && cfg_start && !zero_start) state_nx = LOAD;
        else if (state == LOAD && s_valid) state_nx = EMIT;
        else if (state == EMIT && m_ready && (is_last || lane_last)) state_nx = is_last ? IDLE : LOAD;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            num    <= '0;
            lane   <= '0;
            word   <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= zero_start || (state == EMIT && m_ready && is_last);
            if (state == IDLE && cfg_start) begin
                num  <= cfg_num_values;
                cnt  <= '0;
                lane <= '0;
            end
            if (state == LOAD && s_valid) begin
                word   <= s_data;
                lane   <= '0;
                data_q <= f_dequantize(s_data[DATA_WIDTH-1:0]);
            end
            // leftover lanes of a short final word are simply never selected
            if (state == EMIT && m_ready) begin
                cnt <= cnt_inc;
                if (!is_last && !lane_last) begin
                    lane   <= lane_nx;
                    data_q <= f_dequantize(word[lane_nx*DATA_WIDTH +: DATA_WIDTH]);
                end
            end
        end
    end
endmodule

// File: tb/tb_nvp_bias_dequantizer.sv
// tb_nvp_bias_dequantizer: directed table-driven checks of the bias dequantizer stream
module tb_nvp_bias_dequantizer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [15:0] cfg_num_values;
    logic        busy, done;
    logic [63:0] s_data;
    logic        s_valid, s_ready;
    logic [47:0] m_data;
    logic        m_valid, m_ready, m_last;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic [15:0] din;
        logic [47:0] dout;
    } vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    nvp_bias_dequantizer #(.WORD_LANES(4), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_values(cfg_num_values),
        .busy(busy), .done(done), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input int w);
        logic [63:0] r;
        for (int l = 0; l < 4; l++) r[l*16 +: 16] = tbl[(w*4+l) % 12].din;
        return r;
    endfunction

    // One transfer with s_valid held high: every s_ready is a handshake, so the
    // handshake count also proves no extra word is requested.
    task automatic run(input int num, input int pct, input int inject_at, input int abort_at);
        int cyc, out_idx, hs, words;
        logic stall, pl;
        logic [47:0] pd;
        bit fin;
        words = (num + 3) / 4;
        cyc = 0; out_idx = 0; hs = 0; stall = 0; fin = 0; pd = '0; pl = 0;
        @(negedge clk);
        cfg_start = 1; cfg_num_values = 16'(num); s_valid = 0; m_ready = 0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            cfg_start = (cyc == inject_at);
            cfg_num_values = (cyc == inject_at) ? 16'd1 : 16'(num);
            if (stall) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_data", 64'(m_data), 64'(pd));
                chk("hold_last", 64'(m_last), 64'(pl));
            end
            if (done) begin
                chk("done_count", 64'(out_idx), 64'(num));
                chk("done_busy", 64'(busy), 64'd0);
                chk("done_mvalid", 64'(m_valid), 64'd0);
                chk("done_sready", 64'(s_ready), 64'd0);
                chk("done_hs", 64'(hs), 64'(words));
                if (pct == 100) chk("done_cycle", 64'(cyc), 64'(1 + words + num));
                fin = 1;
            end else if (cyc > 400) begin
                checks++; errors++;
                $display("FAIL timeout: got no done after %0d cycles, num %0d", cyc, num);
                fin = 1;
            end else if (abort_at > 0 && out_idx == abort_at) begin
                rst = 1; m_ready = 0; s_valid = 0;
                fin = 1;
            end else begin
                if (m_valid) begin
                    if (out_idx >= num) chk("extra_out", 64'(m_valid), 64'd0);
                    else begin
                        chk($sformatf("data%0d", out_idx), 64'(m_data), 64'(tbl[out_idx % 12].dout));
                        chk($sformatf("last%0d", out_idx), 64'(m_last), 64'(out_idx == num - 1));
                    end
                end
                m_ready = ($urandom_range(99) < pct);
                stall = m_valid && !m_ready;
                pd = m_data; pl = m_last;
                if (m_valid && m_ready) out_idx++;
                s_valid = 1; s_data = word_of(hs);
                if (s_ready) hs++;
            end
        end
        cfg_start = 0; s_valid = 0; m_ready = 0;
        if (abort_at == 0) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("done_single", 64'(done), 64'd0);
                chk("idle_busy", 64'(busy), 64'd0);
            end
        end
    endtask

    initial begin
        tbl[0]  = '{16'h7FFF, 48'h0000007FFF00};
        tbl[1]  = '{16'h0100, 48'h000000010000};
        tbl[2]  = '{16'h0080, 48'h000000008000};
        tbl[3]  = '{16'hFF00, 48'hFFFFFFFF0000};
        tbl[4]  = '{16'h0000, 48'h000000000000};
        tbl[5]  = '{16'h8000, 48'hFFFFFF800000};
        tbl[6]  = '{16'hFFFF, 48'hFFFFFFFFFF00};
        tbl[7]  = '{16'h0001, 48'h000000000100};
        tbl[8]  = '{16'h1234, 48'h000000123400};
        tbl[9]  = '{16'hABCD, 48'hFFFFFFABCD00};
        tbl[10] = '{16'h00FF, 48'h00000000FF00};
        tbl[11] = '{16'hC000, 48'hFFFFFFC00000};
        rst = 1; cfg_start = 0; cfg_num_values = 0; s_data = 0; s_valid = 0; m_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sready", 64'(s_ready), 64'd0);
        chk("rst_mvalid", 64'(m_valid), 64'd0);
        chk("rst_mlast", 64'(m_last), 64'd0);
        chk("rst_mdata", 64'(m_data), 64'd0);
        rst = 0;
        run(4, 100, 0, 0);
        run(6, 100, 0, 0);
        run(11, 50, 0, 0);
        run(0, 100, 0, 0);
        run(8, 100, 0, 2);
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_sready", 64'(s_ready), 64'd0);
        chk("mid_rst_mvalid", 64'(m_valid), 64'd0);
        chk("mid_rst_mlast", 64'(m_last), 64'd0);
        chk("mid_rst_mdata", 64'(m_data), 64'd0);
        rst = 0;
        run(4, 100, 0, 0);
        run(8, 100, 4, 0);
        run(13, 30, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nvp_bias_dequantizer.md
# nvp_bias_dequantizer

Streaming dequantizer and unpacker. It reads packed words of quantized 8.8 fixed-point `data_t` values (bias or residual operands) from memory-side logic and emits them one at a time as `unquantized_t` accumulator-format values (32.16) to preload the MAC accumulators. It is the inverse direction of the output quantize path and sits between the operand buffer and the accumulator array.

## Interface
Parameters:
- `WORD_LANES`, default 4: number of `data_t` values packed per input word.
- `COUNT_WIDTH`, default 16: width of the value counter.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: synchronous, active-high reset.
- `cfg_start`, in, 1: start a transfer; sampled only in IDLE.
- `cfg_num_values`, in, COUNT_WIDTH: number of values to emit; sampled with `cfg_start`.
- `busy`, out, 1: high whenever state is not IDLE.
- `done`, out, 1: one-cycle pulse when the transfer completes.
- `s_data`, in, WORD_LANES*DATA_WIDTH: packed input word; lane 0 is `[DATA_WIDTH-1:0]`.
- `s_valid`, in, 1: input word valid.
- `s_ready`, out, 1: input word accepted when high together with `s_valid`.
- `m_data`, out, UNQUANTIZED_WIDTH: dequantized value.
- `m_valid`, out, 1: output valid.
- `m_ready`, in, 1: downstream accepts.
- `m_last`, out, 1: marks the final value of the transfer; qualified by `m_valid`.

## Operation
- Dequantize: sign-extend the `data_t` to UNQUANTIZED_WIDTH, then shift left by HALF_DATA_WIDTH. The result is exact. For in-range results, f_quantize(f_dequantize(x)) == x.
- FSM states:
  - **IDLE**: all outputs low except `m_data`, which holds its value. On `cfg_start`:
    - If `cfg_num_values == 0`: pulse `done` next cycle and stay in IDLE.
    - Otherwise: latch the count, clear the value counter and lane index, and go to LOAD.
  - **LOAD**: `s_ready = 1`. On `s_valid`:
    - Register the word.
    - Set lane = 0.
    - Register `m_data = dequant(lane 0)`.
    - Set `m_valid = 1` and go to EMIT.
  - **EMIT**: `m_valid = 1`. On `m_ready`, increment the value counter, then:
    - If counter+1 == num: go to IDLE, drop `m_valid`, pulse `done`.
    - Else if lane == WORD_LANES-1: go to LOAD and drop `m_valid`.
    - Else: increment lane and load the next lane's value into `m_data`, keeping `m_valid` high.
- `m_last = 1` while in EMIT and counter == num-1.
- Unused lanes of the final word (when num is not a multiple of WORD_LANES) are discarded. No extra input word is requested.
- `cfg_start` while busy is ignored and has no effect on the running transfer.
- Reset mid-operation: next cycle the block is in IDLE. Any partial word is discarded and the counter is cleared.

## Timing
- Reset values: `busy = 0`, `done = 0`, `s_ready = 0`, `m_valid = 0`, `m_last = 0`, `m_data = 0`.
- `cfg_start` to `s_ready`: 1 cycle.
- Input handshake to first `m_valid`: 1 cycle (`m_data` is registered).
- Throughput:
  - Within a word: one value per cycle under continuous `m_ready`.
  - Per word: one LOAD bubble cycle, so WORD_LANES+1 cycles per word.
- `m_data`, `m_valid` and `m_last` must stay stable while `m_valid && !m_ready`.
- `done` asserts the cycle after the final output handshake; `busy` falls in that same cycle.
- `s_ready` is never high outside LOAD, so there is no combinational path from `m_ready` to `s_ready`.

## Structure
- Shared package (`NVP_v1_package`):
  - Types `data_t` and `unquantized_t`.
  - Function `f_dequantize(data_t) -> unquantized_t`.
  - State enum `dequant_state_t {IDLE, LOAD, EMIT}`.
- Constants stay in `NVP_v1_constants`: DATA_WIDTH=16, HALF_DATA_WIDTH=8, UNQUANTIZED_WIDTH=48.
- No sub-module. The lane mux and the dequantize function are inline in one module.

## Test plan
- **Single word, num=4.** Input lanes 0..3 = 0x7FFF, 0x0100, 0x0080, 0xFF00 produce, in order:
  - 0x00007FFF00
  - 0x000000010000
  - 0x000000008000
  - 0xFFFFFFFF0000 (`m_last` on this 4th value)
  - Then `done` pulses one cycle later.
- **Partial final word, num=6.** Two words are accepted and six outputs emitted. Lanes 2–3 of word 2 are never emitted, and `s_ready` stays low after the second handshake.
- **Backpressure.** With random `m_ready` (≈50%) and num=11, `m_data` is held stable during stalls, all 11 values arrive in order, and there are exactly 3 input handshakes.
- **Zero length, num=0.** `done` pulses on cycle 1 after start; `s_ready`, `m_valid` and `busy` stay 0.
- **Reset mid-stream.** Assert `rst` after 2 of 8 outputs. Next cycle all outputs are 0. A new start with num=4 then emits from lane 0 of a fresh word.
- **Start while busy.** `cfg_start` with num=1 during an num=8 transfer: exactly 8 outputs and a single `done` pulse.
